// File: rtl/uart_fifo_param_pkg.sv
// Shared constants and elaboration helpers for the parametrised UART FIFO.
package uart_fifo_param_pkg;

  localparam int UART_FIFO_DW    = 8;
  localparam int UART_FIFO_DEPTH = 32;
  localparam int UART_FIFO_AF    = 28;
  localparam int UART_FIFO_AE    = 4;

  function automatic int fifoClog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// Handshake and status bundle between the UART controller and the FIFO.
interface uart_fifo_param_if
  import uart_fifo_param_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DW,
  parameter int DEPTH  = UART_FIFO_DEPTH
) ();

  localparam int CW = fifoClog2(DEPTH) + 1;

  logic              flush;
  logic              write_request;
  logic [DATA_W-1:0] data_in;
  logic              read_request;
  logic              clear_err;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, write_request, data_in, read_request, clear_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, write_request, data_in, read_request, clear_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_param_ram.sv
// Dual-port storage array; no reset so it maps onto block or distributed RAM.
module uart_fifo_param_ram
  import uart_fifo_param_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DW,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int AW     = fifoClog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [AW-1:0]     wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic              rdEn_i,
  input  logic [AW-1:0]     rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdData_q;

  // Same-address read and write returns the old entry (read-before-write).
  always_ff @(posedge clk) begin
    if (wrEn_i) mem[wrAddr_i] <= wrData_i;
    if (rdEn_i) rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags and sticky errors.
module uart_fifo_param
  import uart_fifo_param_pkg::*;
#(
  parameter int DATA_W   = UART_FIFO_DW,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AF_LEVEL = UART_FIFO_AF,
  parameter int AE_LEVEL = UART_FIFO_AE
) (
  input  logic               clk,
  input  logic               SYS_reset,
  uart_fifo_param_if.slave   fifo_io
);

  localparam int AW = fifoClog2(DEPTH);
  localparam int CW = AW + 1;

  if (!isPow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("uart_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("uart_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              almostFull_q, almostFull_d, almostEmpty_q, almostEmpty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] holdData_q, ramData, dataOut;
  logic              wrRaw, rdRaw, wrOk, rdOk;

  // Raw acceptance ignores flush so a flushed request is not seen as an error.
  always_comb begin
    rdRaw         = fifo_io.read_request & ~empty_q;
    wrRaw         = fifo_io.write_request & (~full_q | rdRaw);
    rdOk          = rdRaw & ~fifo_io.flush;
    wrOk          = wrRaw & ~fifo_io.flush;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    valid_d       = rdOk;
    if (fifo_io.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      wrPtr_d     = wrPtr_q + AW'(wrOk);
      rdPtr_d     = rdPtr_q + AW'(rdOk);
      count_d     = count_q + CW'(wrOk) - CW'(rdOk);
      overflow_d  = (fifo_io.write_request & ~wrRaw) | (overflow_q & ~fifo_io.clear_err);
      underflow_d = (fifo_io.read_request & ~rdRaw) | (underflow_q & ~fifo_io.clear_err);
    end
    full_d        = (count_d == CW'(DEPTH));
    empty_d       = (count_d == '0);
    almostFull_d  = (count_d >= CW'(AF_LEVEL));
    almostEmpty_d = (count_d <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      valid_q       <= 1'b0;
      holdData_q    <= '0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      valid_q       <= valid_d;
      holdData_q    <= dataOut;
    end
  end

  uart_fifo_param_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk      (clk),
    .wrEn_i   (wrOk & ~SYS_reset),
    .wrAddr_i (wrPtr_q),
    .wrData_i (fifo_io.data_in),
    .rdEn_i   (rdOk & ~SYS_reset),
    .rdAddr_i (rdPtr_q),
    .rdData_o (ramData)
  );

  // The RAM register carries fresh data only in the valid cycle; otherwise the last value is held.
  assign dataOut = valid_q ? ramData : holdData_q;

  assign fifo_io.data_out     = dataOut;
  assign fifo_io.data_valid   = valid_q;
  assign fifo_io.full         = full_q;
  assign fifo_io.empty        = empty_q;
  assign fifo_io.almost_full  = almostFull_q;
  assign fifo_io.almost_empty = almostEmpty_q;
  assign fifo_io.count        = count_q;
  assign fifo_io.overflow     = overflow_q;
  assign fifo_io.underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed scoreboard bench for uart_fifo_param at DATA_W=8, DEPTH=32, AF=28, AE=4.
module tb_uart_fifo_param;

  localparam int DEPTH = 32;

  logic clk;
  logic sysReset;
  int   checks;
  int   failures;

  logic [7:0] expQ[$];
  logic [7:0] modelQ[$];

  uart_fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) fifoBus ();

  uart_fifo_param #(
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .AF_LEVEL (28),
    .AE_LEVEL (4)
  ) dut (
    .clk       (clk),
    .SYS_reset (sysReset),
    .fifo_io   (fifoBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every data_valid pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (fifoBus.data_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL readData: data_valid with data_out=%h, required no read pending", fifoBus.data_out);
      end else begin
        logic [7:0] exp;
        exp = expQ.pop_front();
        if (fifoBus.data_out !== exp) begin
          failures++;
          $display("[TB] FAIL readData: got %h, required %h", fifoBus.data_out, exp);
        end
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [7:0] din, input bit rd,
                               input bit fl, input bit clr, input bit rst);
    bit rdOk, wrOk;
    if (rst || fl) begin
      modelQ.delete();
    end else begin
      rdOk = rd && (modelQ.size() > 0);
      wrOk = wr && ((modelQ.size() < DEPTH) || rdOk);
      if (rdOk) expQ.push_back(modelQ.pop_front());
      if (wrOk) modelQ.push_back(din);
    end
    fifoBus.write_request = wr;
    fifoBus.data_in       = din;
    fifoBus.read_request  = rd;
    fifoBus.flush         = fl;
    fifoBus.clear_err     = clr;
    sysReset              = rst;
    @(posedge clk);
    #1;
    fifoBus.write_request = 1'b0;
    fifoBus.read_request  = 1'b0;
    fifoBus.flush         = 1'b0;
    fifoBus.clear_err     = 1'b0;
    sysReset              = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, int'(fifoBus.count), 0);
    checkOutput({tag, "_empty"}, int'(fifoBus.empty), 1);
    checkOutput({tag, "_full"}, int'(fifoBus.full), 0);
    checkOutput({tag, "_almostEmpty"}, int'(fifoBus.almost_empty), 1);
    checkOutput({tag, "_almostFull"}, int'(fifoBus.almost_full), 0);
    checkOutput({tag, "_dataValid"}, int'(fifoBus.data_valid), 0);
    checkOutput({tag, "_dataOut"}, int'(fifoBus.data_out), 0);
    checkOutput({tag, "_overflow"}, int'(fifoBus.overflow), 0);
    checkOutput({tag, "_underflow"}, int'(fifoBus.underflow), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fifoBus.write_request = 1'b0;
    fifoBus.data_in       = 8'h00;
    fifoBus.read_request  = 1'b0;
    fifoBus.flush         = 1'b0;
    fifoBus.clear_err     = 1'b0;
    sysReset              = 1'b1;
    @(posedge clk);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    checkResetState("reset");

    // Fill 0x00..0x1F, checking the almost-full and full boundaries.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 8'(i), 0, 0, 0, 0);
      if (i == 26) checkOutput("fill_afAt27", int'(fifoBus.almost_full), 0);
      if (i == 27) checkOutput("fill_afAt28", int'(fifoBus.almost_full), 1);
      if (i == 30) checkOutput("fill_fullAt31", int'(fifoBus.full), 0);
    end
    checkOutput("fill_full", int'(fifoBus.full), 1);
    checkOutput("fill_count", int'(fifoBus.count), 32);
    checkOutput("fill_empty", int'(fifoBus.empty), 0);

    for (int k = 1; k <= 32; k++) begin
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
      checkOutput("drain_validPulse", int'(fifoBus.data_valid), 1);
      if (k == 27) checkOutput("drain_aeAt5", int'(fifoBus.almost_empty), 0);
      if (k == 28) checkOutput("drain_aeAt4", int'(fifoBus.almost_empty), 1);
    end
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("drain_validDrop", int'(fifoBus.data_valid), 0);
    checkOutput("drain_dataHold", int'(fifoBus.data_out), 8'h1F);
    checkOutput("drain_empty", int'(fifoBus.empty), 1);
    checkOutput("drain_count", int'(fifoBus.count), 0);

    // Overflow at full, then clear.
    for (int i = 0; i < 32; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
    applyStimulus(1, 8'hAA, 0, 0, 0, 0);
    checkOutput("ovf_flag", int'(fifoBus.overflow), 1);
    checkOutput("ovf_count", int'(fifoBus.count), 32);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    checkOutput("ovf_clear", int'(fifoBus.overflow), 0);

    // Simultaneous read and write at full.
    applyStimulus(1, 8'h55, 1, 0, 0, 0);
    checkOutput("simFull_count", int'(fifoBus.count), 32);
    checkOutput("simFull_full", int'(fifoBus.full), 1);
    checkOutput("simFull_oldest", int'(fifoBus.data_out), 8'h00);
    checkOutput("simFull_noOvf", int'(fifoBus.overflow), 0);
    for (int k = 0; k < 32; k++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("simFull_last55", int'(fifoBus.data_out), 8'h55);
    checkOutput("simFull_emptyAfter", int'(fifoBus.empty), 1);
    checkOutput("simFull_noUnf", int'(fifoBus.underflow), 0);

    // Simultaneous read and write at empty: no fall-through.
    applyStimulus(1, 8'h3C, 1, 0, 0, 0);
    checkOutput("simEmpty_valid", int'(fifoBus.data_valid), 0);
    checkOutput("simEmpty_underflow", int'(fifoBus.underflow), 1);
    checkOutput("simEmpty_count", int'(fifoBus.count), 1);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("simEmpty_readValid", int'(fifoBus.data_valid), 1);
    checkOutput("simEmpty_read3C", int'(fifoBus.data_out), 8'h3C);
    checkOutput("simEmpty_stickyUnf", int'(fifoBus.underflow), 1);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    checkOutput("simEmpty_clearUnf", int'(fifoBus.underflow), 0);

    // Wrap-around: 40 rounds of 3 in, 3 out.
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 3; j++) applyStimulus(1, 8'(r * 3 + j), 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
    end
    checkOutput("wrap_lastData", int'(fifoBus.data_out), 8'h77);
    checkOutput("wrap_count", int'(fifoBus.count), 0);

    // Flush with a concurrent write discards everything.
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0, 0, 0);
    checkOutput("flush_preCount", int'(fifoBus.count), 10);
    applyStimulus(1, 8'hEE, 0, 1, 0, 0);
    checkOutput("flush_count", int'(fifoBus.count), 0);
    checkOutput("flush_empty", int'(fifoBus.empty), 1);
    checkOutput("flush_almostEmpty", int'(fifoBus.almost_empty), 1);
    checkOutput("flush_dataHold", int'(fifoBus.data_out), 8'h77);
    checkOutput("flush_noOvf", int'(fifoBus.overflow), 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("flush_writeDropped", int'(fifoBus.data_valid), 0);
    checkOutput("flush_underflow", int'(fifoBus.underflow), 1);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h90 + i), 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("burst_data91", int'(fifoBus.data_out), 8'h91);
    applyStimulus(0, 8'h00, 1, 0, 0, 1);
    checkResetState("midReset");

    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
